// File: rtl/jit_pipe_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jit_pipe_pkg
// Purpose  : Shared payload type and compute function for jit_pipe_arbiter.
//            Payload packing, MSB first: {tag, data, lo8}.
// Revision : 1.0 - initial release
// ============================================================================
package jit_pipe_pkg;

    localparam int DATA_W    = 16;
    localparam int PAYLOAD_W = 1 + DATA_W + 8;

    typedef struct packed {
        logic              tag;
        logic [DATA_W-1:0] data;
        logic [7:0]        lo8;
    } payload_t;

    // sel=1 -> modular sum (carry dropped), sel=0 -> xor
    function automatic payload_t compute(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic              sel);
        payload_t p;
        p.data = sel ? (a + b) : (a ^ b);
        p.tag  = (a == b);
        p.lo8  = p.data[7:0];
        return p;
    endfunction

endpackage
`default_nettype wire

// File: rtl/jit_pipe_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : jit_pipe_arbiter_if
// Purpose  : Request/result bundle of jit_pipe_arbiter.
//            master : requester fabric + downstream consumer side
//            slave  : the arbiter/pipeline
//            req_*  : NREQ valid/ready request ports, operands packed by DW
//            out_*  : result valid/ready port, hold, occupancy/idle status
// Revision : 1.0 - initial release
// ============================================================================
interface jit_pipe_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int DW    = 16,
    parameter int DEPTH = 3
);
    localparam int IDW = $clog2(NREQ);
    localparam int OCW = $clog2(DEPTH + 1);

    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [NREQ*DW-1:0] req_a;
    logic [NREQ*DW-1:0] req_b;
    logic [NREQ-1:0]    req_sel;
    logic               hold;
    logic               out_valid;
    logic               out_ready;
    logic [IDW-1:0]     out_id;
    logic               out_tag;
    logic [DW-1:0]      out_data;
    logic [7:0]         out_lo8;
    logic [OCW-1:0]     occupancy;
    logic               idle;

    modport master (
        output req_valid, req_a, req_b, req_sel, hold, out_ready,
        input  req_ready, out_valid, out_id, out_tag, out_data, out_lo8,
               occupancy, idle
    );

    modport slave (
        input  req_valid, req_a, req_b, req_sel, hold, out_ready,
        output req_ready, out_valid, out_id, out_tag, out_data, out_lo8,
               occupancy, idle
    );
endinterface
`default_nettype wire

// File: rtl/jit_pipe_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jit_rr_arbiter
// Purpose  : Round-robin arbiter. Grants the first valid requester at or
//            after the pointer (upward, with wrap); pointer moves past the
//            winner only when a grant is actually taken.
// Ports    : sys_clk, sys_rst_n   clock / async active-low reset
//            req_valid_i           per-requester valid
//            advance_i             pipeline can take an entry this cycle
//            grant_o               one-hot grant (zero when no accept)
//            grant_idx_o           index of the selected requester
//            accept_o              a handshake happens this cycle
// Revision : 1.0 - initial release
// ============================================================================
module jit_rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  wire logic            sys_clk,
    input  wire logic            sys_rst_n,
    input  wire logic [NREQ-1:0] req_valid_i,
    input  wire logic            advance_i,
    output logic      [NREQ-1:0] grant_o,
    output logic      [IDW-1:0]  grant_idx_o,
    output logic                 accept_o
);

    logic [IDW-1:0] ptr_q;
    logic [IDW-1:0] ptr_d;
    logic [IDW-1:0] w_idx;
    logic           w_any;

    always_comb begin
        int j;
        w_idx = '0;
        w_any = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!w_any && req_valid_i[j]) begin
                w_any = 1'b1;
                w_idx = IDW'(j);
            end
        end
    end

    assign accept_o    = advance_i & w_any;
    assign grant_idx_o = w_idx;
    assign grant_o     = accept_o ? (NREQ'(1) << w_idx) : '0;

    always_comb begin
        ptr_d = ptr_q;
        if (accept_o) ptr_d = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) ptr_q <= '0;
        else            ptr_q <= ptr_d;
    end

endmodule
`default_nettype wire

// File: rtl/jit_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : jit_pipe_arbiter
// Purpose  : Shares one DEPTH-stage compute pipeline among NREQ requesters
//            with round-robin arbitration, bubble collapse and output
//            backpressure. Results leave in accept order.
// Ports    : sys_clk    clock, rising edge
//            sys_rst_n  asynchronous active-low reset
//            bus        jit_pipe_arbiter_if.slave (requests, result, status)
// Revision : 1.0 - initial release
// ============================================================================
module jit_pipe_arbiter
    import jit_pipe_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int DEPTH = 3,
    parameter int DW    = DATA_W,
    parameter int IDW   = $clog2(NREQ)
) (
    input  wire logic         sys_clk,
    input  wire logic         sys_rst_n,
    jit_pipe_arbiter_if.slave bus
);

    localparam int PW  = 1 + DW + 8;
    localparam int OCW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_q;
    logic [IDW-1:0]   id_q [DEPTH];
    logic [PW-1:0]    pl_q [DEPTH];

    logic [DEPTH-1:0] w_adv;
    logic             w_accept;
    logic [NREQ-1:0]  w_grant;
    logic [IDW-1:0]   w_gidx;
    logic [DW-1:0]    w_a;
    logic [DW-1:0]    w_b;
    logic             w_sel;
    logic [PW-1:0]    w_pl;
    logic [OCW-1:0]   w_occ;

    // Advance chain from the output back: a stage may move when it is empty
    // or when the stage after it moves, so bubbles collapse under a stall.
    always_comb begin
        logic chain;
        w_adv = '0;
        chain = !v_q[DEPTH-1] | bus.out_ready;
        w_adv[DEPTH-1] = chain;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            chain    = !v_q[k] | chain;
            w_adv[k] = chain;
        end
    end

    jit_rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .req_valid_i (bus.req_valid),
        .advance_i   (w_adv[0] & !bus.hold),
        .grant_o     (w_grant),
        .grant_idx_o (w_gidx),
        .accept_o    (w_accept)
    );

    assign w_a   = bus.req_a[w_gidx*DW +: DW];
    assign w_b   = bus.req_b[w_gidx*DW +: DW];
    assign w_sel = bus.req_sel[w_gidx];

    generate
        if (DW == DATA_W) begin : g_pkg_compute
            assign w_pl = compute(w_a, w_b, w_sel);
        end else begin : g_gen_compute
            logic [DW-1:0] w_data;
            assign w_data = w_sel ? (w_a + w_b) : (w_a ^ w_b);
            assign w_pl   = {(w_a == w_b), w_data, w_data[7:0]};
        end
    endgenerate

    // Payload/ID only load when a valid entry moves in; a stage that moves
    // out with nothing arriving simply drops its valid bit.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v_q <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                id_q[k] <= '0;
                pl_q[k] <= '0;
            end
        end else begin
            if (w_adv[0]) begin
                v_q[0] <= w_accept;
                if (w_accept) begin
                    id_q[0] <= w_gidx;
                    pl_q[0] <= w_pl;
                end
            end
            for (int k = 1; k < DEPTH; k++) begin
                if (w_adv[k]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        id_q[k] <= id_q[k-1];
                        pl_q[k] <= pl_q[k-1];
                    end
                end
            end
        end
    end

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < DEPTH; k++) w_occ = w_occ + OCW'(v_q[k]);
    end

    assign bus.req_ready = w_grant;
    assign bus.out_valid = v_q[DEPTH-1];
    assign bus.out_id    = id_q[DEPTH-1];
    assign {bus.out_tag, bus.out_data, bus.out_lo8} = pl_q[DEPTH-1];
    assign bus.occupancy = w_occ;
    assign bus.idle      = (w_occ == '0);

endmodule
`default_nettype wire

// File: tb/tb_jit_pipe_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_jit_pipe_arbiter
// Purpose  : Self-checking bench for jit_pipe_arbiter (NREQ=4, DEPTH=3,
//            DW=16). Stimulus pushes hand-computed results into a queue;
//            a monitor pops and compares on every output handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jit_pipe_arbiter;

    typedef struct packed {
        logic [1:0]  id;
        logic        tag;
        logic [15:0] data;
        logic [7:0]  lo8;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sb[$];

    logic [15:0] fa   [4] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000};
    logic [15:0] fb   [4] = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
    logic [15:0] fres [4] = '{16'h1011, 16'h2022, 16'h3033, 16'h4044};

    jit_pipe_arbiter_if #(.NREQ(4), .DW(16), .DEPTH(3)) ifc ();

    jit_pipe_arbiter #(.NREQ(4), .DEPTH(3), .DW(16)) dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] id, input logic tag,
                                input logic [15:0] data, input logic [7:0] lo8);
        exp_t e;
        e.id = id; e.tag = tag; e.data = data; e.lo8 = lo8;
        return e;
    endfunction

    task automatic set_req(input int r, input logic [15:0] a,
                           input logic [15:0] b, input logic s);
        ifc.req_a[r*16 +: 16] = a;
        ifc.req_b[r*16 +: 16] = b;
        ifc.req_sel[r]        = s;
    endtask

    // Monitor: every output handshake must match the head of the scoreboard
    always @(negedge clk) begin
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(ifc.out_data), 32'hFFFF_FFFF);
            end else begin
                check("result", 32'({ifc.out_id, ifc.out_tag, ifc.out_data, ifc.out_lo8}),
                      32'(sb.pop_front()));
            end
        end
    end

    // Single request with exact-latency check: out_valid rises DEPTH cycles
    // after the request cycle.
    task automatic single(input int r, input logic [15:0] a, input logic [15:0] b,
                          input logic s, input exp_t e);
        logic [3:0] v;
        v = '0;
        v[r] = 1'b1;
        set_req(r, a, b, s);
        ifc.req_valid = v;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        check("single_ready", 32'(ifc.req_ready), 32'(v));
        sb.push_back(e);
        @(posedge clk); #1;
        ifc.req_valid = '0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("latency", 32'(ifc.out_valid), 32'(c == 2));
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        n_tests++;
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        rst_n         = 1'b0;
        ifc.req_valid = '0;
        ifc.req_a     = '0;
        ifc.req_b     = '0;
        ifc.req_sel   = '0;
        ifc.hold      = 1'b0;
        ifc.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_occupancy", 32'(ifc.occupancy), 32'd0);
        check("rst_idle",      32'(ifc.idle),      32'd1);
        check("rst_out_data",  32'(ifc.out_data),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Compute: sum, xor, wraparound, equality tag
        single(0, 16'h1234, 16'h1111, 1'b1, mk(2'd0, 1'b0, 16'h2345, 8'h45));
        single(0, 16'h1234, 16'h1111, 1'b0, mk(2'd0, 1'b0, 16'h0325, 8'h25));
        single(2, 16'hFFFF, 16'h0001, 1'b1, mk(2'd2, 1'b0, 16'h0000, 8'h00));
        single(1, 16'h00FF, 16'h00FF, 1'b1, mk(2'd1, 1'b1, 16'h01FE, 8'hFE));

        // Async reset with two entries in flight (one at the output)
        ifc.out_ready = 1'b0;
        set_req(3, 16'h0AAA, 16'h0555, 1'b0);
        ifc.req_valid = 4'b1000;
        @(negedge clk);
        check("rr_wrap_ready3", 32'(ifc.req_ready), 32'b1000);
        @(posedge clk); #1;
        set_req(0, 16'h0001, 16'h0001, 1'b1);
        ifc.req_valid = 4'b0001;
        @(negedge clk);
        check("rr_wrap_ready0", 32'(ifc.req_ready), 32'b0001);
        @(posedge clk); #1;
        ifc.req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_occ",   32'(ifc.occupancy), 32'd2);
        check("pre_rst_valid", 32'(ifc.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        for (int r = 0; r < 4; r++) set_req(r, fa[r], fb[r], 1'b0);
        ifc.req_valid = 4'b1111;
        ifc.out_ready = 1'b1;
        #1;
        check("arst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("arst_occupancy", 32'(ifc.occupancy), 32'd0);
        check("arst_idle",      32'(ifc.idle),      32'd1);
        check("arst_ptr_grant", 32'(ifc.req_ready), 32'b0001);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Fairness: all valid, out_ready high -> 0,1,2,3,0,1,2,3
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("fair_grant", 32'(ifc.req_ready), 32'(4'b0001 << (i % 4)));
            sb.push_back(mk(2'(i % 4), 1'b0, fres[i % 4], fres[i % 4][7:0]));
            @(posedge clk); #1;
        end
        ifc.req_valid = '0;
        repeat (4) @(posedge clk);
        #1;

        // Backpressure: fill with out_ready low, then release for one cycle
        ifc.out_ready = 1'b0;
        set_req(1, 16'h0001, 16'h0002, 1'b1);
        ifc.req_valid = 4'b0010;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_fill_ready", 32'(ifc.req_ready), 32'b0010);
            check("bp_fill_occ",   32'(ifc.occupancy), 32'(i));
            sb.push_back(mk(2'd1, 1'b0, 16'h0003, 8'h03));
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_full_ready", 32'(ifc.req_ready), 32'd0);
        check("bp_full_occ",   32'(ifc.occupancy), 32'd3);
        check("bp_full_valid", 32'(ifc.out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_held_valid", 32'(ifc.out_valid), 32'd1);
        @(posedge clk); #1;
        ifc.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(ifc.req_ready), 32'b0010);
        sb.push_back(mk(2'd1, 1'b0, 16'h0003, 8'h03));
        @(posedge clk); #1;
        ifc.out_ready = 1'b0;
        @(negedge clk);
        check("bp_after_occ",   32'(ifc.occupancy), 32'd3);
        check("bp_after_ready", 32'(ifc.req_ready), 32'd0);
        @(posedge clk); #1;
        ifc.req_valid = '0;
        ifc.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("bp_drained_idle", 32'(ifc.idle), 32'd1);

        // Bubble collapse: A, one empty cycle, B, all under output stall
        ifc.out_ready = 1'b0;
        set_req(2, 16'h00F0, 16'h000F, 1'b0);
        ifc.req_valid = 4'b0100;
        @(negedge clk);
        check("bub_ready_a", 32'(ifc.req_ready), 32'b0100);
        sb.push_back(mk(2'd2, 1'b0, 16'h00FF, 8'hFF));
        @(posedge clk); #1;
        ifc.req_valid = '0;
        @(posedge clk); #1;
        set_req(3, 16'h0005, 16'h0005, 1'b0);
        ifc.req_valid = 4'b1000;
        @(negedge clk);
        check("bub_ready_b", 32'(ifc.req_ready), 32'b1000);
        sb.push_back(mk(2'd3, 1'b1, 16'h0000, 8'h00));
        @(posedge clk); #1;
        ifc.req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("bub_occ",   32'(ifc.occupancy), 32'd2);
        check("bub_valid", 32'(ifc.out_valid), 32'd1);
        @(posedge clk); #1;

        // Hold: no accepts while the two adjacent entries drain back-to-back
        ifc.hold      = 1'b1;
        ifc.req_valid = 4'b1111;
        ifc.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("hold_out_valid", 32'(ifc.out_valid), 32'(c < 2));
            check("hold_ready",     32'(ifc.req_ready), 32'd0);
        end
        check("hold_idle", 32'(ifc.idle),      32'd1);
        check("hold_occ",  32'(ifc.occupancy), 32'd0);
        @(posedge clk); #1;
        ifc.hold      = 1'b0;
        ifc.req_valid = '0;
        repeat (2) @(posedge clk);
        #1;
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
